// File: rtl/rv32i_branch_pkg.sv
// Shared types and helpers for the RV32I branch predictor / resolution controller.
package rv32i_branch_pkg;

  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {SNT, WNT, WT, ST} bht_ctr_t;

  typedef enum logic {S_RUN, S_FLUSH} bpc_state_t;

  // Saturating 2-bit counter step toward the observed outcome.
  function automatic bht_ctr_t bht_next(bht_ctr_t c, logic taken);
    bht_ctr_t n;
    n = c;
    if (taken) begin
      if (c != ST) n = bht_ctr_t'(c + 2'd1);
    end else begin
      if (c != SNT) n = bht_ctr_t'(c - 2'd1);
    end
    return n;
  endfunction

endpackage

// File: rtl/bht_table.sv
// Branch history table: array of 2-bit saturating counters.
// Async read for the IF prediction, sync read-modify-write update from EX resolution.
// A read to an entry being written in the same cycle sees the old value (no bypass).
module bht_table
  import rv32i_branch_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output bht_ctr_t         rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  bht_ctr_t ctr [ENTRIES];

  assign rd_ctr = ctr[rd_idx];

  // Reset every entry to weakly-not-taken; otherwise train the addressed entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= WNT;
    end else if (wr_en) begin
      ctr[wr_idx] <= bht_next(ctr[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Fetch-side branch predictor and EX-side mispredict resolution.
// Optional feature: define BRANCH_STATS_EN to add saturating branch/mispredict counters.
//
// state   | meaning
// S_RUN   | normal operation; predictions issued, EX branches resolved
// S_FLUSH | squashing younger stages after a mispredict; EX inputs ignored
module branch_predict_ctrl
  import rv32i_branch_pkg::*;
#(
  parameter int BHT_ENTRIES  = 64,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_valid,
  input  logic        if_is_branch,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_imm,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_pred_taken,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  bpc_state_t       state, state_next;
  logic [CNT_W-1:0] flush_cnt, flush_cnt_next;

  logic             resolve, mispredict;
  logic             res_valid, res_taken;
  logic [IDX_W-1:0] res_idx;
  bht_ctr_t         rd_ctr;
  logic             unused_ctr_lsb;

  assign resolve    = ex_valid & ex_is_branch & (state == S_RUN);
  assign mispredict = resolve & (ex_taken != ex_pred_taken);

  bht_table #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_bht (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (if_pc[IDX_W+1:2]),
    .rd_ctr   (rd_ctr),
    .wr_en    (res_valid),
    .wr_idx   (res_idx),
    .wr_taken (res_taken)
  );

  assign unused_ctr_lsb = rd_ctr[0];

  assign pred_taken  = if_valid & if_is_branch & rd_ctr[1] & (state == S_RUN);
  assign pred_target = if_pc + if_imm;
  assign flush       = (state == S_FLUSH);

  // Next-state logic: enter FLUSH on mispredict, count down, return when the count is spent.
  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    case (state)
      S_RUN: begin
        if (mispredict) begin
          state_next     = S_FLUSH;
          flush_cnt_next = CNT_W'(FLUSH_CYCLES - 1);
        end
      end
      S_FLUSH: begin
        if (flush_cnt == '0) state_next = S_RUN;
        else                 flush_cnt_next = flush_cnt - 1'b1;
      end
      default: begin
        state_next     = S_RUN;
        flush_cnt_next = '0;
      end
    endcase
  end

  // State and flush down-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_RUN;
      flush_cnt <= '0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
    end
  end

  // Capture the resolved branch so the BHT is trained one edge later.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_idx   <= '0;
      res_taken <= 1'b0;
    end else begin
      res_valid <= resolve;
      res_idx   <= ex_pc[IDX_W+1:2];
      res_taken <= ex_taken;
    end
  end

  // One-cycle redirect pulse; the corrected address is held until the next mispredict.
  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= mispredict;
      if (mispredict) redirect_pc <= ex_taken ? ex_target : ex_pc + 32'(INSTR_BYTES);
    end
  end

`ifdef BRANCH_STATS_EN
  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (resolve && stat_branches != 32'hFFFF_FFFF)       stat_branches    <= stat_branches + 32'd1;
      if (mispredict && stat_mispredicts != 32'hFFFF_FFFF) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl; expected values flow through a scoreboard queue.
module tb_branch_predict_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid, if_is_branch;
  logic [31:0] if_pc, if_imm;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid, ex_is_branch, ex_pred_taken, ex_taken;
  logic [31:0] ex_pc, ex_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  always #5 clk = ~clk;

  branch_predict_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .if_valid       (if_valid),
    .if_is_branch   (if_is_branch),
    .if_pc          (if_pc),
    .if_imm         (if_imm),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_pc          (ex_pc),
    .ex_pred_taken  (ex_pred_taken),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ex(input logic v, input logic [31:0] pc, input logic pt,
                        input logic t, input logic [31:0] tgt);
    ex_valid      = v;
    ex_is_branch  = 1'b1;
    ex_pc         = pc;
    ex_pred_taken = pt;
    ex_taken      = t;
    ex_target     = tgt;
  endtask

  initial begin
    reset        = 1'b1;
    if_valid     = 1'b1;
    if_is_branch = 1'b1;
    if_pc        = 32'h100;
    if_imm       = 32'h20;
    set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // 1. reset state
    cyc(); cyc();
    sb_push("pred_in_reset", 32'd0);
    #1 sb_check({31'd0, pred_taken});
    reset = 1'b0;
    cyc();
    sb_push("rst_redirect_valid", 32'd0);
    sb_push("rst_flush", 32'd0);
    sb_push("rst_redirect_pc", 32'd0);
    sb_push("rst_pred_taken", 32'd0);
    sb_push("rst_pred_target", 32'h120);
    sb_check({31'd0, redirect_valid});
    sb_check({31'd0, flush});
    sb_check(redirect_pc);
    sb_check({31'd0, pred_taken});
    sb_check(pred_target);

    // 2. train 0x100 taken twice, correctly predicted
    set_ex(1'b1, 32'h100, 1'b1, 1'b1, 32'h120);
    cyc();
    sb_push("collision_pre_update", 32'd0);
    sb_push("train_no_redirect", 32'd0);
    sb_push("train_no_flush", 32'd0);
    sb_check({31'd0, pred_taken});
    sb_check({31'd0, redirect_valid});
    sb_check({31'd0, flush});
    cyc();
    ex_valid = 1'b0;
    sb_push("pred_weak_taken", 32'd1);
    #1 sb_check({31'd0, pred_taken});
    cyc();
    sb_push("pred_strong_taken", 32'd1);
    sb_push("pred_target_trained", 32'h120);
    sb_push("train2_no_redirect", 32'd0);
    sb_check({31'd0, pred_taken});
    sb_check(pred_target);
    sb_check({31'd0, redirect_valid});
    // one not-taken step from 11 must still predict taken
    set_ex(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
    cyc();
    ex_valid = 1'b0;
    sb_push("nt_correct_no_redirect", 32'd0);
    #1 sb_check({31'd0, redirect_valid});
    cyc();
    sb_push("pred_after_st_dec", 32'd1);
    sb_check({31'd0, pred_taken});
    ex_valid = 1'b1;
    cyc();
    ex_valid = 1'b0;
    cyc();
    sb_push("pred_after_wt_dec", 32'd0);
    sb_check({31'd0, pred_taken});

    // 3. mispredict taken at 0x200 (aliases BHT index of 0x100)
    set_ex(1'b1, 32'h200, 1'b0, 1'b1, 32'h240);
    cyc();
    // 5. branch presented during flush, would mispredict if resolved
    set_ex(1'b1, 32'h14, 1'b0, 1'b1, 32'h80);
    sb_push("mp_redirect_valid", 32'd1);
    sb_push("mp_redirect_pc", 32'h240);
    sb_push("mp_flush_n1", 32'd1);
    sb_push("mp_pred_gated_n1", 32'd0);
    #1;
    sb_check({31'd0, redirect_valid});
    sb_check(redirect_pc);
    sb_check({31'd0, flush});
    sb_check({31'd0, pred_taken});
    cyc();
    sb_push("mp_redirect_pulse_end", 32'd0);
    sb_push("mp_flush_n2", 32'd1);
    sb_push("mp_pred_gated_n2", 32'd0);
    sb_push("mp_redirect_pc_hold", 32'h240);
    sb_check({31'd0, redirect_valid});
    sb_check({31'd0, flush});
    sb_check({31'd0, pred_taken});
    sb_check(redirect_pc);
    cyc();
    ex_valid = 1'b0;
    sb_push("flush_done", 32'd0);
    sb_push("ignored_no_redirect_n3", 32'd0);
    sb_push("pred_after_flush", 32'd1);
    #1;
    sb_check({31'd0, flush});
    sb_check({31'd0, redirect_valid});
    sb_check({31'd0, pred_taken});
    cyc();
    if_pc = 32'h14;
    sb_push("ignored_no_redirect_n4", 32'd0);
    sb_push("ignored_no_train", 32'd0);
    #1;
    sb_check({31'd0, redirect_valid});
    sb_check({31'd0, pred_taken});
    if_pc = 32'h100;

    // 4. mispredict not taken at top of address space, fall-through wraps
    set_ex(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h1234);
    cyc();
    ex_valid = 1'b0;
    sb_push("wrap_redirect_valid", 32'd1);
    sb_push("wrap_redirect_pc", 32'h0);
    sb_push("wrap_flush", 32'd1);
    #1;
    sb_check({31'd0, redirect_valid});
    sb_check(redirect_pc);
    sb_check({31'd0, flush});

    // 6. reset in the middle of the flush window
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    sb_push("midrst_flush", 32'd0);
    sb_push("midrst_redirect_valid", 32'd0);
    sb_push("midrst_redirect_pc", 32'd0);
    sb_push("midrst_bht_reinit", 32'd0);
    #1;
    sb_check({31'd0, flush});
    sb_check({31'd0, redirect_valid});
    sb_check(redirect_pc);
    sb_check({31'd0, pred_taken});
`ifdef BRANCH_STATS_EN
    sb_push("midrst_stat_branches", 32'd0);
    sb_push("midrst_stat_mispredicts", 32'd0);
    sb_check(stat_branches);
    sb_check(stat_mispredicts);
`endif

    // correct prediction after reset: training only
    set_ex(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
    cyc();
    ex_valid = 1'b0;
    sb_push("correct_no_redirect", 32'd0);
    sb_push("correct_no_flush", 32'd0);
    #1;
    sb_check({31'd0, redirect_valid});
    sb_check({31'd0, flush});
`ifdef BRANCH_STATS_EN
    sb_push("stat_branches_one", 32'd1);
    sb_push("stat_mispredicts_zero", 32'd0);
    sb_check(stat_branches);
    sb_check(stat_mispredicts);
    force dut.stat_branches    = 32'hFFFF_FFFF;
    force dut.stat_mispredicts = 32'hFFFF_FFFF;
    cyc();
    release dut.stat_branches;
    release dut.stat_mispredicts;
    set_ex(1'b1, 32'h300, 1'b0, 1'b1, 32'h400);
    cyc();
    ex_valid = 1'b0;
    sb_push("stat_branches_sat", 32'hFFFF_FFFF);
    sb_push("stat_mispredicts_sat", 32'hFFFF_FFFF);
    #1;
    sb_check(stat_branches);
    sb_check(stat_mispredicts);
`endif

    n_checks++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
